// File: rtl/axis_replay_source.sv
// AXI4-Stream replay source: beats are preloaded into an internal buffer and then played back
// with backpressure, programmable inter-beat gaps, optional looping and stop at a frame end.
module axis_replay_source #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned GAP_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [KEEP_WIDTH-1:0] wr_keep,
    input  logic                  wr_last,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop_en,
    input  logic [GAP_WIDTH-1:0]  gap_cycles,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           frame_count,
    output logic                  overflow,
    output logic                  start_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned EW = DATA_WIDTH + KEEP_WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

    state_e                  r_state;
    state_e                  w_state_next;

    logic [EW-1:0]           r_mem [DEPTH];
    logic [LW-1:0]           r_len;
    logic [AW-1:0]           r_rd_ptr;
    logic                    r_loop;
    logic [GAP_WIDTH-1:0]    r_gap;
    logic [GAP_WIDTH-1:0]    r_gap_cnt;
    logic                    r_stop_req;
    logic                    r_done;
    logic                    r_overflow;
    logic                    r_start_err;
    logic [15:0]             r_frame_count;
    logic [DATA_WIDTH-1:0]   r_tdata;
    logic [KEEP_WIDTH-1:0]   r_tkeep;
    logic                    r_tlast;

    logic                    w_idle;
    logic                    w_hs;
    logic                    w_at_end;
    logic                    w_final;
    logic [AW-1:0]           w_next_ptr;
    logic                    w_do_clear;
    logic                    w_do_start;
    logic                    w_launch;
    logic                    w_do_write;

    assign w_idle     = (r_state == StIdle);
    assign w_hs       = (r_state == StPlay) & m_axis_tready;
    assign w_at_end   = ({1'b0, r_rd_ptr} == (r_len - LW'(1)));
    // Looping never ends on its own; only a pending stop makes a beat final.
    assign w_final    = r_loop ? (r_stop_req & (r_tlast | w_at_end))
                               : (w_at_end | (r_tlast & r_stop_req));
    assign w_next_ptr = w_at_end ? '0 : (r_rd_ptr + AW'(1));
    assign w_do_clear = w_idle & clear;
    assign w_do_start = w_idle & ~clear & start;
    assign w_launch   = w_do_start & (r_len != '0);
    assign w_do_write = w_idle & ~clear & ~start & wr_en & (r_len != LW'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_launch) w_state_next = StPlay;
            end
            StPlay: begin
                if (w_hs) begin
                    if (w_final) begin
                        w_state_next = StIdle;
                    end else if (r_gap != '0) begin
                        w_state_next = StGap;
                    end
                end
            end
            StGap: begin
                if (r_gap_cnt <= GAP_WIDTH'(1)) w_state_next = StPlay;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        m_axis_tvalid = (r_state == StPlay);
        busy          = (r_state != StIdle);
        m_axis_tdata  = r_tdata;
        m_axis_tkeep  = r_tkeep;
        m_axis_tlast  = r_tlast;
        done          = r_done;
        frame_count   = r_frame_count;
        overflow      = r_overflow;
        start_err     = r_start_err;
    end

    // Buffer contents survive reset; only the length is cleared.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            r_mem[r_len[AW-1:0]] <= {wr_last, wr_keep, wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len         <= '0;
            r_rd_ptr      <= '0;
            r_loop        <= 1'b0;
            r_gap         <= '0;
            r_gap_cnt     <= '0;
            r_stop_req    <= 1'b0;
            r_done        <= 1'b0;
            r_overflow    <= 1'b0;
            r_start_err   <= 1'b0;
            r_frame_count <= '0;
            r_tdata       <= '0;
            r_tkeep       <= '0;
            r_tlast       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_do_clear) begin
                r_len       <= '0;
                r_overflow  <= 1'b0;
                r_start_err <= 1'b0;
            end
            if (w_do_write) r_len <= r_len + LW'(1);
            // A write coinciding with clear is silently discarded.
            if (wr_en & ~w_do_clear & ~w_do_write) r_overflow <= 1'b1;
            if (w_do_start & (r_len == '0)) r_start_err <= 1'b1;
            if (w_launch) begin
                r_loop                       <= loop_en;
                r_gap                        <= gap_cycles;
                r_rd_ptr                     <= '0;
                r_frame_count                <= '0;
                r_stop_req                   <= 1'b0;
                {r_tlast, r_tkeep, r_tdata}  <= r_mem[0];
            end
            if (~w_idle & stop) r_stop_req <= 1'b1;
            if (w_hs) begin
                if (r_tlast) r_frame_count <= r_frame_count + 16'd1;
                if (w_final) begin
                    r_done     <= 1'b1;
                    r_stop_req <= 1'b0;
                end else begin
                    r_rd_ptr                    <= w_next_ptr;
                    {r_tlast, r_tkeep, r_tdata} <= r_mem[w_next_ptr];
                    r_gap_cnt                   <= r_gap;
                end
            end
            if (r_state == StGap) r_gap_cnt <= r_gap_cnt - GAP_WIDTH'(1);
        end
    end

endmodule

// File: doc/axis_replay_source.md
# axis_replay_source

Parametrised, synthesizable AXI4-Stream beat source that is the successor to the testbench file reader. A host or testbench preloads beats (data, keep, last) into an internal buffer, then triggers playback. Playback honours `m_axis_tready` backpressure, and supports programmable inter-beat gaps, continuous looping and a graceful stop at a frame boundary. It sits in front of the packet parser as a stimulus and replay engine usable both in simulation and on hardware.

## Interface
Parameters:
- DATA_WIDTH, 64, tdata width in bits; must be a multiple of 8
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width
- DEPTH, 256, buffer entries; power of two, at least 2
- GAP_WIDTH, 8, width of `gap_cycles`

Ports (clk, then rst; one clock; reset is synchronous and active-high):
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  load one beat into the buffer
- wr_data  in  DATA_WIDTH  beat data to load
- wr_keep  in  KEEP_WIDTH  beat keep to load
- wr_last  in  1  beat last to load
- clear  in  1  empty the buffer (sets length to 0)
- start  in  1  begin playback
- stop  in  1  request stop at the next frame end
- loop_en  in  1  repeat the buffer continuously; sampled on start
- gap_cycles  in  GAP_WIDTH  idle cycles after each accepted beat; sampled on start
- m_axis_tdata  out  DATA_WIDTH  stream data
- m_axis_tkeep  out  KEEP_WIDTH  stream keep
- m_axis_tlast  out  1  stream last
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready
- busy  out  1  playback in progress
- done  out  1  one-cycle pulse when playback ends
- frame_count  out  16  number of tlast beats accepted since start; wraps
- overflow  out  1  sticky: a write was dropped
- start_err  out  1  sticky: start was issued while the buffer was empty

## Operation
- Length register `len` (0..DEPTH). In IDLE, `wr_en` writes to `mem[len]` and increments `len`.
- Priority in IDLE: `clear` > `start` > `wr_en`.
  - A `clear` together with `wr_en` drops the write; `overflow` is not set.
  - A `start` together with `wr_en` drops the write; `overflow` is set.
- A write is dropped and `overflow` is set when `len==DEPTH`, or when the block is busy.
- `clear` and `start` are ignored while busy.
- `overflow` and `start_err` are cleared only by `rst` or `clear`.
- States: IDLE, PLAY, GAP.
  - IDLE, `start` with `len==0`: set `start_err` and remain in IDLE.
  - IDLE, `start` with `len>0`: latch `loop_en` and `gap_cycles`, set `rd_ptr=0`, zero `frame_count`, go to PLAY.
  - PLAY: `tvalid=1`, and the outputs present `mem[rd_ptr]`. Outputs remain stable until handshake (`tvalid & tready`).
  - On handshake, if the beat was the final beat: go to IDLE and pulse `done`. Otherwise advance `rd_ptr`, wrapping to 0 after `len-1`, and go to GAP if the latched gap is greater than 0, else remain in PLAY.
  - Final beat definition:
    - With loop off: the beat at `rd_ptr==len-1`, or a tlast beat while a stop request is pending.
    - With loop on: a tlast beat while a stop request is pending, or the beat at `len-1` while a stop request is pending.
  - GAP: `tvalid=0` for exactly the latched number of cycles, then return to PLAY.
- `stop` is latched as a pending stop request (`stop_req`) while busy, and cleared on return to IDLE. `stop` in IDLE is ignored.
- `frame_count` increments on each accepted beat with `tlast=1`.
- A stored last entry without `wr_last` is still emitted; no tlast is synthesised.
- `rst` mid-playback: abort immediately with no `done` pulse, and set `len=0`. Memory contents are not reset.

## Timing
- Reset values: `tvalid`, `tdata`, `tkeep`, `tlast`, `busy`, `done`, `frame_count`, `overflow` and `start_err` are all 0. State is IDLE.
- `start` at cycle N puts the first beat on the outputs with `tvalid=1` at N+1. `busy` is 1 from N+1.
- With `tready` held high and gap 0: one beat per cycle, with no bubble at the wrap from `len-1` to 0.
- With gap G: beats are accepted at cycles T, T+G+1, T+2(G+1), and so on.
- Final handshake at cycle T: at T+1 `tvalid=0`, `busy=0` and `done=1`, and `done=0` again at T+2. `frame_count` is updated at T+1.
- `tvalid` never drops without a handshake. Output registers change only on handshake or state entry.
- `overflow` and `start_err` assert the cycle after the offending request.

## Test plan
- Load 3 beats (0x11/0xFF/0, 0x22/0xFF/0, 0x33/0x0F/1), `start` with `tready=1` and gap 0 -> beats accepted on 3 consecutive cycles, `done` one cycle after 0x33, `frame_count=1`.
- Same load with `tready` toggling 1,0,0,1,... -> order and values unchanged, `tvalid` never drops while waiting, exactly 3 handshakes.
- Gap 2, 3 beats -> handshakes exactly 3 cycles apart, `tvalid=0` during the 2 gap cycles.
- `loop_en=1`, 2 frames of 2 beats each, `stop` asserted mid-way through the 3rd frame -> that frame completes, `done` pulses after its tlast beat, `frame_count=3`.
- Fill DEPTH entries then write once more; also `start` with `len==0` after `clear`; also `wr_en` while busy -> `overflow=1`, `len` stays DEPTH; `start_err=1`, block stays IDLE; the busy-time write does not alter playback.
- `rst` asserted during PLAY -> the next cycle has all outputs 0 and `busy=0` with no `done` pulse; a subsequent `start` sets `start_err` because `len=0`.
